// File: rtl/module_control_calc_pkg.sv
// Shared types and key codes for the keypad calculator controller.
package pkg_calc;

  typedef enum logic [3:0] {
    ESP_A,
    WR_A,
    ESP_OP,
    ESP_B,
    WR_B,
    ESP_EN,
    EXEC,
    RES,
    MOSTRAR
  } estado_t;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLR    = 4'hF;
  localparam logic [3:0] KEY_OP_MIN = 4'hB;
  localparam logic [3:0] KEY_OP_MAX = 4'hE;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'h9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_OP_MIN) && (k <= KEY_OP_MAX);
  endfunction

endpackage

// File: rtl/module_control_calc.sv
// Keypad calculator sequencer: steers register-file writes and ALU operands of
// module_datapath from debounced key strobes. Every output is registered.
module module_control_calc
  import pkg_calc::*;
#(
  parameter int ADDR_W     = 5,
  parameter int REG_A      = 1,
  parameter int REG_B      = 2,
  parameter int REG_RES    = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tecla_valida_i,
  input  logic [3:0]        teclado_i,
  output logic [3:0]        tecla_o,
  output logic              mux_sel,
  output logic [ADDR_W-1:0] addr_rs1,
  output logic [ADDR_W-1:0] addr_rs2,
  output logic [ADDR_W-1:0] addr_rd,
  output logic              we_banco,
  output logic [3:0]        op_alu,
  output logic              ocupado_o,
  output logic              error_o
);

  localparam logic [ADDR_W-1:0] ADDR_A   = ADDR_W'(REG_A);
  localparam logic [ADDR_W-1:0] ADDR_B   = ADDR_W'(REG_B);
  localparam logic [ADDR_W-1:0] ADDR_RES = ADDR_W'(REG_RES);
  localparam logic [2:0]        SETTLE_LAST = 3'(SETTLE_CYC - 1);

  estado_t           state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        tecla_q, tecla_d;
  logic [3:0]        op_q, op_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic              mux_q, mux_d;
  logic              ocup_q, ocup_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tecla_d = tecla_q;
    op_d    = op_q;
    err_d   = err_q;
    busy    = (state_q == WR_A) || (state_q == WR_B) ||
              (state_q == EXEC) || (state_q == RES);

    case (state_q)
      WR_A:    state_d = ESP_OP;
      WR_B:    state_d = ESP_EN;
      EXEC: begin
        if (cnt_q == SETTLE_LAST) state_d = RES;
        else                      cnt_d   = cnt_q + 3'd1;
      end
      RES:     state_d = MOSTRAR;
      default: ;
    endcase

    // Keys arriving while a write/execute is in flight are lost but flagged.
    if (tecla_valida_i) begin
      if (busy) begin
        err_d = 1'b1;
      end else begin
        tecla_d = teclado_i;
        if (teclado_i == KEY_CLR) begin
          state_d = ESP_A;
          err_d   = 1'b0;
          op_d    = 4'h0;
        end else if (is_digit(teclado_i)) begin
          state_d = ((state_q == ESP_B) || (state_q == ESP_EN)) ? WR_B : WR_A;
        end else if (is_op(teclado_i)) begin
          case (state_q)
            ESP_OP: begin
              op_d    = teclado_i;
              state_d = ESP_B;
            end
            ESP_B, ESP_EN: op_d = teclado_i;
            default:       err_d = 1'b1;
          endcase
        end else begin
          if ((state_q == ESP_EN) || (state_q == MOSTRAR)) begin
            state_d = EXEC;
            cnt_d   = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  // Output registers are loaded from the state being entered, so each output
  // is valid for exactly the cycle spent in that state.
  always_comb begin
    we_d   = (state_d == WR_A) || (state_d == WR_B) || (state_d == RES);
    mux_d  = (state_d == EXEC) || (state_d == RES);
    ocup_d = (state_d == WR_A) || (state_d == WR_B) ||
             (state_d == EXEC) || (state_d == RES);
    rs1_d  = ADDR_A;
    rs2_d  = ADDR_A;
    rd_d   = ADDR_A;
    case (state_d)
      WR_B:      rd_d  = ADDR_B;
      ESP_EN:    rs2_d = ADDR_B;
      EXEC:      rs2_d = ADDR_B;
      RES: begin
        rs2_d = ADDR_B;
        rd_d  = ADDR_RES;
      end
      MOSTRAR:   rs2_d = ADDR_RES;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ESP_A;
      cnt_q   <= 3'd0;
      tecla_q <= 4'h0;
      op_q    <= 4'h0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      mux_q   <= 1'b0;
      ocup_q  <= 1'b0;
      rs1_q   <= ADDR_A;
      rs2_q   <= ADDR_A;
      rd_q    <= ADDR_A;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tecla_q <= tecla_d;
      op_q    <= op_d;
      err_q   <= err_d;
      we_q    <= we_d;
      mux_q   <= mux_d;
      ocup_q  <= ocup_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
    end
  end

  assign tecla_o   = tecla_q;
  assign op_alu    = op_q;
  assign error_o   = err_q;
  assign we_banco  = we_q;
  assign mux_sel   = mux_q;
  assign ocupado_o = ocup_q;
  assign addr_rs1  = rs1_q;
  assign addr_rs2  = rs2_q;
  assign addr_rd   = rd_q;

endmodule

// File: doc/module_control_calc.md
Name: module_control_calc

Overview:
FSM controller that sequences module_datapath as a 4-bit keypad calculator.
- Latches keypad presses and writes operand A to reg 1 and operand B to reg 2.
- Latches the operator, then on Enter runs the ALU and writes the result to reg 3.
- Selects which register drives seg_o by steering addr_rs2.
- Sits between the keypad debouncer/encoder and module_datapath.

Parameters:
ADDR_W, 5, register-file address width
REG_A, 1, register holding operand A
REG_B, 2, register holding operand B
REG_RES, 3, register holding the result
SETTLE_CYC, 1, cycles operands/op_alu are held stable before the result write (1..7)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tecla_valida_i  in  1  one-cycle strobe: new key on teclado_i
teclado_i  in  4  key code: 0x0-0x9 digit, 0xA enter, 0xB-0xE operator, 0xF clear
tecla_o  out  4  registered key, drives datapath teclado_i
mux_sel  out  1  0 = write key, 1 = write ALU result
addr_rs1  out  ADDR_W  ALU operand 1 address
addr_rs2  out  ADDR_W  ALU operand 2 / display address
addr_rd  out  ADDR_W  write address
we_banco  out  1  register-file write enable
op_alu  out  4  ALU operation
ocupado_o  out  1  high in write/execute states; keys are dropped
error_o  out  1  sticky: key dropped or illegal key for state; cleared by 0xF or reset

Behaviour:
- All outputs are registered.
- Reset values: state ESP_A, tecla_o=0, mux_sel=0, we_banco=0, op_alu=0, addr_rd=REG_A, addr_rs1=REG_A, addr_rs2=REG_A, ocupado_o=0, error_o=0, settle counter=0.
- Reset mid-operation aborts immediately. No write occurs in the cycle after reset is asserted.
- Key capture: on a strobe in an accepting state, tecla_o<=teclado_i in the same edge. The write state follows on the next cycle.
- we_banco is a single-cycle pulse with tecla_o stable. Write latency from strobe to we_banco high is 1 cycle.
- States and transitions:
  - ESP_A: digit -> WR_A. Operator or enter -> ignored, error_o=1. Display addr_rs2=REG_A.
  - WR_A: we_banco=1, mux_sel=0, addr_rd=REG_A -> ESP_OP.
  - ESP_OP: digit -> WR_A (replaces A). Operator 0xB-0xE -> op_alu<=key, -> ESP_B. Enter -> error_o=1, stay. Display REG_A.
  - ESP_B: digit -> WR_B. New operator -> op_alu replaced, stay. Enter -> error_o=1. Display REG_A.
  - WR_B: we_banco=1, mux_sel=0, addr_rd=REG_B -> ESP_EN.
  - ESP_EN: digit -> WR_B (replaces B). Operator -> op_alu replaced. Enter -> EXEC, counter<=0. Display REG_B.
  - EXEC:
    - Hold addr_rs1=REG_A, addr_rs2=REG_B, op_alu and mux_sel=1; counter increments.
    - When counter==SETTLE_CYC-1 -> RES.
  - RES: we_banco=1, mux_sel=1, addr_rd=REG_RES, operands held -> MOSTRAR.
  - MOSTRAR: mux_sel=0, addr_rs2=REG_RES (result on seg_o). Digit -> WR_A (new calculation). Operator -> chain: copy not supported, error_o=1. Enter -> re-execute (EXEC).
- Clear (0xF) in any accepting state -> ESP_A, error_o<=0, op_alu<=0. No register writes.
- ocupado_o=1 in WR_A, WR_B, EXEC and RES. A strobe there is dropped, error_o=1, and the state sequence is unaffected. This includes a clear, which is also dropped.
- Strobe coincident with reset: reset wins and the key is lost.
- No arithmetic is done in the controller. Result width and wrap are owned by the datapath ALU.

Decomposition:
- Package pkg_calc holds:
  - typedef enum logic [3:0] estado_t (ESP_A, WR_A, ESP_OP, ESP_B, WR_B, ESP_EN, EXEC, RES, MOSTRAR).
  - Key constants KEY_ENTER=4'hA, KEY_CLR=4'hF, KEY_OP_MIN=4'hB, KEY_OP_MAX=4'hE.
- Single module, no sub-module. The settle counter is 3 bits, inline.

Test Plan:
- Reset, then key 0x2 -> 1 cycle later we_banco=1, addr_rd=1, tecla_o=2, mux_sel=0; next cycle we_banco=0, state ESP_OP.
- Sequence 0x2, 0xB, 0x3, 0xA (keys 4 cycles apart, SETTLE_CYC=1):
  - reg2 written with 3.
  - op_alu=0xB from the 0xB press onward.
  - RES cycle: mux_sel=1, we_banco=1, addr_rd=3, rs1=1, rs2=2.
  - Then addr_rs2=3 and seg_o shows the ALU result.
- Sequence 0x2, 0x5 (digit replaces A), 0xC, 0x4, 0xA -> two writes to reg1 (2 then 5), op_alu=0xC, one result write.
- Key 0xA in ESP_A -> no write, error_o=1. Then 0xF -> error_o=0, state ESP_A.
- Strobe during EXEC with SETTLE_CYC=3 -> key dropped, error_o=1, and the RES write still occurs exactly 3 cycles after EXEC entry.
- Reset asserted in the cycle the FSM is in WR_B -> we_banco=0 on the next edge, all outputs at their reset values.
